csr_counter_bank: RTL and testbench
===================================

CSR_COUNTER_BANK -- requirements
Module: csr_counter_bank

Interface
REQ-001 SHALL have parameter NUM_CNT, default 3, number of event counters; legal range 1..8.
REQ-002 SHALL have parameter CNT_W, default 64, counter width; legal range 33..64.
REQ-003 SHALL have parameter XLEN, default `CSR_XLEN (32), CSR data width.
REQ-004 SHALL have localparam AW = $clog2(2*NUM_CNT+4), CSR address width.
REQ-005 SHALL have port clk, input, 1, the single clock; all state on its rising edge.
REQ-006 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port inc_i, input, NUM_CNT, per-counter increment event; bit n drives counter n.
REQ-008 SHALL have port csr_we_i, input, 1, CSR write strobe.
REQ-009 SHALL have port csr_re_i, input, 1, CSR read strobe.
REQ-010 SHALL have port csr_addr_i, input, AW, register index.
REQ-011 SHALL have port csr_wdata_i, input, XLEN, write data.
REQ-012 SHALL have port csr_rdata_o, output, XLEN, registered read data.
REQ-013 SHALL have port csr_rvalid_o, output, 1, read data valid pulse.
REQ-014 SHALL have port csr_err_o, output, 1, unmapped-access pulse.
REQ-015 SHALL have port timer_irq_o, output, 1, registered compare interrupt, level.

Function
REQ-016 Address map SHALL be: 2n = counter n low half, 2n+1 = counter n high half (bits CNT_W-1:XLEN, zero-extended); 2*NUM_CNT / +1 = compare low/high; 2*NUM_CNT+2 = inhibit (bit n); 2*NUM_CNT+3 = overflow status (bit n, write-1-to-clear).
REQ-017 Counter n SHALL increment by 1 in a cycle where inc_i[n]=1 and inhibit[n]=0, with carry from low into high half.
REQ-018 Counter at 2^CNT_W-1 with increment SHALL wrap to 0 and set overflow[n] in the same edge.
REQ-019 A write to either half of counter n SHALL load that half only, preserve the other half, and suppress that cycle's increment and overflow set.
REQ-020 Writes to inhibited counters SHALL take effect; inhibit affects increment only.
REQ-021 Overflow write SHALL clear bits written 1; a wrap in the same cycle SHALL leave the bit set (set wins).
REQ-022 Read SHALL have one-cycle latency: csr_rvalid_o pulses the cycle after csr_re_i, with csr_rdata_o holding the value present before that edge's update.
REQ-023 Simultaneous read and write to the same address SHALL return the pre-write value.
REQ-024 Access (read or write) to addresses >= 2*NUM_CNT+4 SHALL be ignored, return rdata 0 with rvalid, and pulse csr_err_o one cycle later.
REQ-025 csr_rdata_o SHALL hold its last value when csr_rvalid_o=0.
REQ-026 timer_irq_o SHALL be registered (counter 0 >= compare), asserting the cycle after the condition first holds and deasserting the cycle after it stops holding.
REQ-027 Unused high bits of compare above CNT_W SHALL be ignored on write and read as 0.

Reset
REQ-028 On rst_n low, immediately and regardless of clk: counters 0, compare all ones (CNT_W bits), inhibit 0, overflow 0, csr_rdata_o 0, csr_rvalid_o 0, csr_err_o 0, timer_irq_o 0.
REQ-029 Reset asserted mid-access SHALL abort it; no rvalid/err pulse follows reset release.

Structure
REQ-030 Package csr_counter_pkg SHALL hold the address-offset constants (CMP_LO, CMP_HI, INHIBIT, OVF relative to 2*NUM_CNT) and parameter range checks.
REQ-031 One sub-module csr_counter_slice SHALL implement a single counter (half-writes, increment, wrap, overflow-set output), instantiated NUM_CNT times by generate.

Verification
REQ-032 Reset, inc_i[0]=1 for 5 cycles -> read addr 0 returns 5, addr 1 returns 0, rvalid one cycle after re.
REQ-033 Write lo=0xFFFFFFFF, hi=0xFFFFFFFF to counter 1, one inc_i[1] -> counter 1 = 0, overflow bit1=1; write 0x2 to OVF -> bit1 clears; clear with same-cycle wrap -> bit stays 1.
REQ-034 Inhibit=0b001, inc_i=0b111 for 10 cycles -> counters read 0,10,10; write 7 to counter 0 while inhibited -> reads 7.
REQ-035 Write counter 2 lo=0x10 in a cycle with inc_i[2]=1 -> reads 0x10, not 0x11; read same address same cycle as write returns old value.
REQ-036 Compare=20, inc_i[0] held -> timer_irq_o rises the cycle after counter 0 reaches 20; write compare=0xFFFFFFFF_FFFFFFFF -> drops next cycle; read addr 2*NUM_CNT+4 -> rdata 0, csr_err_o pulse.

Source files
------------

// File: rtl/csr_counter_pkg.sv
// Shared constants and parameter checks for the CSR event-counter bank.
`ifndef CSR_XLEN
`define CSR_XLEN 32
`endif

package csr_counter_pkg;

    // Register offsets relative to the first register after the counters
    localparam int CMP_LO_OFS  = 0;
    localparam int CMP_HI_OFS  = 1;
    localparam int INHIBIT_OFS = 2;
    localparam int OVF_OFS     = 3;

    function automatic bit params_ok(int num_cnt, int cnt_w, int xlen);
        return (num_cnt >= 1) && (num_cnt <= 8) &&
               (cnt_w >= 33) && (cnt_w <= 64) &&
               (cnt_w > xlen) && (cnt_w <= 2 * xlen);
    endfunction

endpackage

// File: rtl/csr_counter_slice.sv
// One event counter: split low/high CSR writes, gated increment and
// a wrap indication that is valid in the same cycle as the increment.
module csr_counter_slice
    import csr_counter_pkg::*;
#(
    parameter int CNT_W = 64,
    parameter int XLEN  = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc_i,
    input  logic             we_lo_i,
    input  logic             we_hi_i,
    input  logic [XLEN-1:0]  wdata_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             ovf_set_o
);

    localparam int HW = CNT_W - XLEN;

    logic [CNT_W-1:0] cnt_d, cnt_q;

    // A CSR write wins over the event and suppresses its wrap
    always_comb begin
        cnt_d     = cnt_q;
        ovf_set_o = 1'b0;
        if (we_lo_i) begin
            cnt_d[XLEN-1:0] = wdata_i;
        end else if (we_hi_i) begin
            cnt_d[CNT_W-1:XLEN] = wdata_i[HW-1:0];
        end else if (inc_i) begin
            cnt_d     = cnt_q + CNT_W'(1);
            ovf_set_o = &cnt_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/csr_counter_bank.sv
// Bank of CSR-mapped event counters with compare interrupt, inhibit
// mask and sticky overflow flags; reads return one cycle later.
module csr_counter_bank
    import csr_counter_pkg::*;
#(
    parameter int  NUM_CNT = 3,
    parameter int  CNT_W   = 64,
    parameter int  XLEN    = `CSR_XLEN,
    localparam int AW      = $clog2(2 * NUM_CNT + 4)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_CNT-1:0] inc_i,
    input  logic               csr_we_i,
    input  logic               csr_re_i,
    input  logic [AW-1:0]      csr_addr_i,
    input  logic [XLEN-1:0]    csr_wdata_i,
    output logic [XLEN-1:0]    csr_rdata_o,
    output logic               csr_rvalid_o,
    output logic               csr_err_o,
    output logic               timer_irq_o
);

    localparam int BASE = 2 * NUM_CNT;
    localparam int HW   = CNT_W - XLEN;

    if (!params_ok(NUM_CNT, CNT_W, XLEN)) begin : g_bad_params
        $error("csr_counter_bank: illegal NUM_CNT/CNT_W/XLEN");
    end

    logic [31:0] addr;
    logic        mapped;

    assign addr   = 32'(csr_addr_i);
    assign mapped = addr < 32'(BASE + 4);

    logic [NUM_CNT-1:0][CNT_W-1:0] cnt;
    logic [NUM_CNT-1:0]            ovf_set;
    logic [NUM_CNT-1:0]            inhibit_d, inhibit_q;
    logic [NUM_CNT-1:0]            ovf_d, ovf_q, ovf_clr;
    logic [CNT_W-1:0]              cmp_d, cmp_q;
    logic [XLEN-1:0]               rd_val;
    logic [XLEN-1:0]               rdata_d, rdata_q;
    logic                          rvalid_d, rvalid_q;
    logic                          err_d, err_q;
    logic                          irq_d, irq_q;

    for (genvar n = 0; n < NUM_CNT; n++) begin : g_cnt
        csr_counter_slice #(
            .CNT_W(CNT_W),
            .XLEN (XLEN)
        ) u_slice (
            .clk      (clk),
            .rst_n    (rst_n),
            .inc_i    (inc_i[n] & ~inhibit_q[n]),
            .we_lo_i  (csr_we_i && (addr == 32'(2 * n))),
            .we_hi_i  (csr_we_i && (addr == 32'(2 * n + 1))),
            .wdata_i  (csr_wdata_i),
            .cnt_o    (cnt[n]),
            .ovf_set_o(ovf_set[n])
        );
    end

    always_comb begin
        cmp_d     = cmp_q;
        inhibit_d = inhibit_q;
        ovf_clr   = '0;
        if (csr_we_i) begin
            if (addr == 32'(BASE + CMP_LO_OFS)) begin
                cmp_d[XLEN-1:0] = csr_wdata_i;
            end
            if (addr == 32'(BASE + CMP_HI_OFS)) begin
                cmp_d[CNT_W-1:XLEN] = csr_wdata_i[HW-1:0];
            end
            if (addr == 32'(BASE + INHIBIT_OFS)) begin
                inhibit_d = csr_wdata_i[NUM_CNT-1:0];
            end
            if (addr == 32'(BASE + OVF_OFS)) begin
                ovf_clr = csr_wdata_i[NUM_CNT-1:0];
            end
        end
        // A wrap in the clearing cycle keeps the flag set
        ovf_d = (ovf_q & ~ovf_clr) | ovf_set;
    end

    // Read mux sees pre-edge state, so read-during-write returns old data
    always_comb begin
        rd_val = '0;
        for (int n = 0; n < NUM_CNT; n++) begin
            if (addr == 32'(2 * n)) begin
                rd_val = cnt[n][XLEN-1:0];
            end
            if (addr == 32'(2 * n + 1)) begin
                rd_val = XLEN'(cnt[n][CNT_W-1:XLEN]);
            end
        end
        if (addr == 32'(BASE + CMP_LO_OFS)) begin
            rd_val = cmp_q[XLEN-1:0];
        end
        if (addr == 32'(BASE + CMP_HI_OFS)) begin
            rd_val = XLEN'(cmp_q[CNT_W-1:XLEN]);
        end
        if (addr == 32'(BASE + INHIBIT_OFS)) begin
            rd_val = XLEN'(inhibit_q);
        end
        if (addr == 32'(BASE + OVF_OFS)) begin
            rd_val = XLEN'(ovf_q);
        end
    end

    always_comb begin
        rdata_d  = csr_re_i ? rd_val : rdata_q;
        rvalid_d = csr_re_i;
        err_d    = (csr_re_i || csr_we_i) && !mapped;
        irq_d    = cnt[0] >= cmp_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmp_q     <= '1;
            inhibit_q <= '0;
            ovf_q     <= '0;
            rdata_q   <= '0;
            rvalid_q  <= 1'b0;
            err_q     <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            cmp_q     <= cmp_d;
            inhibit_q <= inhibit_d;
            ovf_q     <= ovf_d;
            rdata_q   <= rdata_d;
            rvalid_q  <= rvalid_d;
            err_q     <= err_d;
            irq_q     <= irq_d;
        end
    end

    assign csr_rdata_o  = rdata_q;
    assign csr_rvalid_o = rvalid_q;
    assign csr_err_o    = err_q;
    assign timer_irq_o  = irq_q;

endmodule

// File: tb/tb_csr_counter_bank.sv
// Directed self-checking bench for csr_counter_bank (3 x 64-bit counters).
module tb_csr_counter_bank;

    localparam int NUM_CNT = 3;
    localparam int CNT_W   = 64;
    localparam int XLEN    = 32;
    localparam int AW      = 4;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [NUM_CNT-1:0] inc;
    logic               we;
    logic               re;
    logic [AW-1:0]      addr;
    logic [XLEN-1:0]    wdata;
    logic [XLEN-1:0]    rdata;
    logic               rvalid;
    logic               err;
    logic               irq;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    csr_counter_bank #(
        .NUM_CNT(NUM_CNT),
        .CNT_W  (CNT_W),
        .XLEN   (XLEN)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .inc_i       (inc),
        .csr_we_i    (we),
        .csr_re_i    (re),
        .csr_addr_i  (addr),
        .csr_wdata_i (wdata),
        .csr_rdata_o (rdata),
        .csr_rvalid_o(rvalid),
        .csr_err_o   (err),
        .timer_irq_o (irq)
    );

    task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        inc   = '0;
        we    = 1'b0;
        re    = 1'b0;
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [XLEN-1:0] d);
        addr  = a;
        wdata = d;
        we    = 1'b1;
        tick();
        we    = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [AW-1:0] a,
                      input logic [XLEN-1:0] exp);
        addr = a;
        re   = 1'b1;
        tick();
        check({tag, "_rvalid"}, 64'(rvalid), 64'd1);
        check(tag, 64'(rdata), 64'(exp));
        re = 1'b0;
    endtask

    initial begin
        inc   = '0;
        we    = 1'b0;
        re    = 1'b0;
        addr  = '0;
        wdata = '0;
        rst_n = 1'b0;
        #2;
        check("rst_rdata", 64'(rdata), 64'd0);
        check("rst_rvalid", 64'(rvalid), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        check("rst_irq", 64'(irq), 64'd0);
        tick();
        rst_n = 1'b1;

        // five events on counter 0
        inc = 3'b001;
        repeat (5) tick();
        inc = '0;
        check("rvalid_idle", 64'(rvalid), 64'd0);
        rd("c0_lo_5", 4'd0, 32'd5);
        rd("c0_hi_0", 4'd1, 32'd0);
        tick();
        check("rvalid_pulse", 64'(rvalid), 64'd0);
        check("rdata_hold", 64'(rdata), 64'd0);
        rd("cmp_lo_rst", 4'd6, 32'hFFFF_FFFF);
        rd("cmp_hi_rst", 4'd7, 32'hFFFF_FFFF);

        // wrap of counter 1 and overflow W1C
        wr(4'd2, 32'hFFFF_FFFF);
        wr(4'd3, 32'hFFFF_FFFF);
        rd("ovf_none", 4'd9, 32'd0);
        inc = 3'b010;
        tick();
        inc = '0;
        rd("c1_lo_wrap", 4'd2, 32'd0);
        rd("c1_hi_wrap", 4'd3, 32'd0);
        rd("ovf_set", 4'd9, 32'd2);
        wr(4'd9, 32'd2);
        rd("ovf_clr", 4'd9, 32'd0);
        wr(4'd2, 32'hFFFF_FFFF);
        wr(4'd3, 32'hFFFF_FFFF);
        inc = 3'b010;
        wr(4'd9, 32'd2);
        inc = '0;
        rd("ovf_set_wins", 4'd9, 32'd2);
        rd("c0_untouched", 4'd0, 32'd5);

        // inhibit mask
        do_reset();
        wr(4'd8, 32'd1);
        inc = 3'b111;
        repeat (10) tick();
        inc = '0;
        rd("inh_c0", 4'd0, 32'd0);
        rd("inh_c1", 4'd2, 32'd10);
        rd("inh_c2", 4'd4, 32'd10);
        rd("inh_rd", 4'd8, 32'd1);
        wr(4'd0, 32'd7);
        rd("inh_wr_c0", 4'd0, 32'd7);

        // carry, write-beats-increment, read-during-write
        do_reset();
        wr(4'd4, 32'hFFFF_FFFF);
        inc = 3'b100;
        tick();
        inc = '0;
        rd("carry_lo", 4'd4, 32'd0);
        rd("carry_hi", 4'd5, 32'd1);
        inc = 3'b100;
        wr(4'd4, 32'h10);
        inc = '0;
        rd("wr_beats_inc", 4'd4, 32'h10);
        rd("hi_kept", 4'd5, 32'd1);
        addr  = 4'd4;
        wdata = 32'h55;
        we    = 1'b1;
        re    = 1'b1;
        tick();
        we    = 1'b0;
        re    = 1'b0;
        check("rdw_old", 64'(rdata), 64'h10);
        rd("rdw_new", 4'd4, 32'h55);
        wr(4'd5, 32'd3);
        rd("lo_kept", 4'd4, 32'h55);
        rd("hi_wr", 4'd5, 32'd3);

        // compare interrupt
        do_reset();
        wr(4'd6, 32'd20);
        wr(4'd7, 32'd0);
        check("irq_below", 64'(irq), 64'd0);
        inc = 3'b001;
        repeat (20) tick();
        check("irq_at20_pre", 64'(irq), 64'd0);
        tick();
        check("irq_rise", 64'(irq), 64'd1);
        inc = '0;
        wr(4'd6, 32'hFFFF_FFFF);
        check("irq_lo_wr", 64'(irq), 64'd1);
        wr(4'd7, 32'hFFFF_FFFF);
        check("irq_drop", 64'(irq), 64'd0);
        rd("cmp_hi_rb", 4'd7, 32'hFFFF_FFFF);
        rd("cnt0_21", 4'd0, 32'd21);

        // unmapped accesses
        rd("unmapped_rd", 4'd10, 32'd0);
        check("err_rd", 64'(err), 64'd1);
        tick();
        check("err_pulse", 64'(err), 64'd0);
        wr(4'd12, 32'hDEAD);
        check("err_wr", 64'(err), 64'd1);
        check("err_wr_rvalid", 64'(rvalid), 64'd0);

        // reset in the middle of a read
        addr = 4'd0;
        re   = 1'b1;
        tick();
        check("mid_rvalid", 64'(rvalid), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rvalid", 64'(rvalid), 64'd0);
        check("async_rdata", 64'(rdata), 64'd0);
        re = 1'b0;
        #1;
        rst_n = 1'b1;
        tick();
        check("post_rst_rvalid", 64'(rvalid), 64'd0);
        check("post_rst_err", 64'(err), 64'd0);
        rd("post_rst_c0", 4'd0, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
